rst_seq_ctrl: RTL and testbench

- Reset sequencer that sits downstream of the team's reset synchronizers.
- Takes an already-synchronized reset request, a clock-locked indication and a software reset pulse.
- Holds all reset domains in reset for a guaranteed minimum time, waits for lock, then releases NUM_STAGES downstream resets one at a time with a fixed gap (e.g. memory, then interconnect, then core, then debug).
- Any new reset cause immediately re-asserts every stage.

---
 rtl/rst_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every downstream reset for a minimum time, waits for
// clock lock, then releases stages one by one (bit 0 first) with a fixed gap.
module rst_seq_ctrl #(
    parameter int NUM_STAGES        = 4,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int STAGE_GAP_CYCLES  = 8,
    parameter int CNT_W             = 8,
    localparam int IDX_W            = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_req_sync,
    input  logic                  locked,
    input  logic                  sw_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  rst_done,
    output logic [IDX_W-1:0]      stage_idx
);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [NUM_STAGES-1:0] ALL_ON   = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] ALL_OFF  = {NUM_STAGES{1'b0}};
    localparam logic [CNT_W-1:0]      HOLD_END = CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_END  = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [NUM_STAGES-1:0]   rst_out_r, rst_out_nxt_s;
    logic                    rst_done_r, rst_done_nxt_s;
    logic [IDX_W-1:0]        stage_idx_r, stage_idx_nxt_s;
    logic                    abort_s;

    // Lock loss only counts as a reset cause once stages may be out of reset.
    assign abort_s = rst_req_sync | sw_rst |
                     (~locked & ((state_r == RELEASE) | (state_r == RUN)));

    // Next-state and next-output logic; abort outranks every transition.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        rst_out_nxt_s   = rst_out_r;
        rst_done_nxt_s  = rst_done_r;
        stage_idx_nxt_s = stage_idx_r;
        if (abort_s) begin
            state_nxt_s     = HOLD;
            cnt_nxt_s       = {CNT_W{1'b0}};
            rst_out_nxt_s   = ALL_ON;
            rst_done_nxt_s  = 1'b0;
            stage_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    rst_out_nxt_s   = ALL_ON;
                    rst_done_nxt_s  = 1'b0;
                    stage_idx_nxt_s = {IDX_W{1'b0}};
                    if (cnt_r == HOLD_END) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = WAIT_LOCK;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = RELEASE;
                    end else begin
                        state_nxt_s = WAIT_LOCK;
                    end
                end
                RELEASE: begin
                    if (cnt_r == GAP_END) begin
                        // Shifting zeros in from the LSB keeps release order thermometer-style.
                        cnt_nxt_s       = {CNT_W{1'b0}};
                        rst_out_nxt_s   = rst_out_r << 1;
                        stage_idx_nxt_s = stage_idx_r + IDX_W'(1);
                        if (stage_idx_r == LAST_IDX) begin
                            rst_done_nxt_s = 1'b1;
                            state_nxt_s    = RUN;
                        end else begin
                            state_nxt_s = RELEASE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    rst_out_nxt_s   = ALL_OFF;
                    rst_done_nxt_s  = 1'b1;
                    stage_idx_nxt_s = IDX_W'(NUM_STAGES);
                end
                default: begin
                    state_nxt_s     = HOLD;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    rst_out_nxt_s   = ALL_ON;
                    rst_done_nxt_s  = 1'b0;
                    stage_idx_nxt_s = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_r   <= ALL_ON;
            rst_done_r  <= 1'b0;
            stage_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rst_out_r   <= rst_out_nxt_s;
            rst_done_r  <= rst_done_nxt_s;
            stage_idx_r <= stage_idx_nxt_s;
        end
    end

    assign rst_out   = rst_out_r;
    assign rst_done  = rst_done_r;
    assign stage_idx = stage_idx_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: directed scenarios push per-cycle expected
// outputs derived from hand-computed release start cycles; a monitor pops and compares.
module tb_rst_seq_ctrl;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] out;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst = 1'b1, rst_req_sync = 1'b0, locked = 1'b1, sw_rst = 1'b0;
    logic [3:0] rst_out;
    logic       rst_done;
    logic [2:0] stage_idx;

    // Single-stage, one-cycle-timing corner instance
    logic       c_rst = 1'b1, c_req = 1'b0, c_locked = 1'b1, c_sw = 1'b0;
    logic [0:0] c_out;
    logic       c_done;
    logic [0:0] c_idx;

    rst_seq_ctrl dut (
        .clk(clk), .rst(rst), .rst_req_sync(rst_req_sync), .locked(locked),
        .sw_rst(sw_rst), .rst_out(rst_out), .rst_done(rst_done), .stage_idx(stage_idx)
    );

    rst_seq_ctrl #(.NUM_STAGES(1), .MIN_ASSERT_CYCLES(1), .STAGE_GAP_CYCLES(1), .CNT_W(8)) u_corner (
        .clk(clk), .rst(c_rst), .rst_req_sync(c_req), .locked(c_locked),
        .sw_rst(c_sw), .rst_out(c_out), .rst_done(c_done), .stage_idx(c_idx)
    );

    exp_t q_main[$];
    exp_t q_cor[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic string kname(input int kind);
        case (kind)
            0: return "default_seq";
            1: return "late_lock";
            2: return "sw_abort_mid";
            3: return "lock_loss_run";
            4: return "req_glitch_hold";
            5: return "sw_level_stuck";
            6: return "corner_1stage";
            default: return "unknown";
        endcase
    endfunction

    // First RELEASE cycle for each scenario, worked out by hand from the timeline.
    function automatic int rel_start(input int kind, input int c);
        case (kind)
            0: return 17;
            1: return 41;
            2: return (c <= 35) ? 17 : 53;
            3: return (c <= 60) ? 17 : 91;
            4: return (c <= 10) ? 17 : 28;
            5: return (c <= 5)  ? 17 : 58;
            6: return (c <= 6)  ? 2  : 9;
            default: return 17;
        endcase
    endfunction

    function automatic exp_t expect_at(input int kind, input int c);
        exp_t e;
        int n, gap, r, k;
        n   = (kind == 6) ? 1 : 4;
        gap = (kind == 6) ? 1 : 8;
        r   = rel_start(kind, c);
        k   = (c < r) ? 0 : ((c - r) / gap);
        if (k > n) k = n;
        e.kind = kind;
        e.cyc  = c;
        e.out  = 4'(((1 << n) - 1) & ~((1 << k) - 1));
        e.done = (k == n);
        e.idx  = 3'(k);
        return e;
    endfunction

    task automatic run_scen(input int kind, input int len);
        for (int c = -4; c < len; c++) begin
            @(posedge clk);
            #1;
            if (c >= -3) begin
                if (kind == 6) q_cor.push_back(expect_at(kind, c));
                else           q_main.push_back(expect_at(kind, c));
            end
            if (kind == 6) begin
                c_rst    = (c < 0);
                c_req    = 1'b0;
                c_locked = 1'b1;
                c_sw     = (c == 6);
            end else begin
                rst          = (c < 0);
                rst_req_sync = (kind == 4) && (c == 10);
                sw_rst       = ((kind == 2) && (c == 35)) || ((kind == 5) && (c >= 5) && (c <= 40));
                locked       = (kind == 1) ? (c >= 40) :
                               (kind == 3) ? !((c >= 60) && (c < 90)) : 1'b1;
            end
        end
    endtask

    // Monitor: outputs are presented every cycle; compare each against the queue head.
    always @(negedge clk) begin
        if (q_main.size() > 0) begin
            exp_t e;
            e = q_main.pop_front();
            vectors++;
            if (rst_out !== e.out || rst_done !== e.done || stage_idx !== e.idx) begin
                miscompares++;
                $display("FAIL %s cyc=%0d rst_out got %h want %h, rst_done got %b want %b, stage_idx got %0d want %0d",
                         kname(e.kind), e.cyc, rst_out, e.out, rst_done, e.done, stage_idx, e.idx);
            end
        end
        if (q_cor.size() > 0) begin
            exp_t e;
            e = q_cor.pop_front();
            vectors++;
            if (c_out !== e.out[0:0] || c_done !== e.done || c_idx !== e.idx[0:0]) begin
                miscompares++;
                $display("FAIL %s cyc=%0d rst_out got %h want %h, rst_done got %b want %b, stage_idx got %0d want %0d",
                         kname(e.kind), e.cyc, c_out, e.out[0:0], c_done, e.done, c_idx, e.idx[0:0]);
            end
        end
    end

    initial begin
        run_scen(0, 60);
        run_scen(1, 80);
        run_scen(2, 90);
        run_scen(3, 130);
        run_scen(4, 65);
        run_scen(5, 100);
        run_scen(6, 12);
        repeat (3) @(posedge clk);
        if (q_main.size() != 0 || q_cor.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue entries left got %0d want 0", q_main.size() + q_cor.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
